// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// It supports sequential advance, stall, PC-relative branch, absolute jump,
// call/return through a circular return-address stack, and an exception
// redirect that captures the EPC. Redirects that would land on a misaligned
// address, and returns with an empty stack, raise a one-cycle fault pulse
// and go to the exception vector.
module pc_unit #(
   parameter int          WIDTH        = 32,
   parameter int          STEP         = 4,
   parameter logic [63:0] RESET_VECTOR = 64'h0,
   parameter logic [63:0] EXC_VECTOR   = 64'h0000_0080,
   parameter int          RAS_DEPTH    = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             stall,
   input  logic                             branch,
   input  logic signed [WIDTH-1:0]          branch_off,
   input  logic                             jump,
   input  logic                             call,
   input  logic                             ret,
   input  logic        [WIDTH-1:0]          target,
   input  logic                             exc,
   output logic        [WIDTH-1:0]          pc_value,
   output logic        [WIDTH-1:0]          pc_seq,
   output logic        [WIDTH-1:0]          epc,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
   output logic                             fault,
   output logic        [1:0]                fault_cause
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_VECTOR);
   localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
   // STEP is a power of two, so the low-bit mask is STEP-1 (all zero when STEP=1,
   // which disables the alignment check without a special case).
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_UFLOW = 2'b10;

   function automatic logic misaligned(input logic [WIDTH-1:0] addr);
      return |(addr & ALIGN_MASK);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
   endfunction

   // Return-address storage; wr_ptr points at the slot the next push fills,
   // so the top of stack is the slot just below it (modulo depth).
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr;

   logic [WIDTH-1:0] top_entry;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] epc_nxt;
   logic             fault_nxt;
   logic [1:0]       cause_nxt;
   logic             push;
   logic             pop;

   assign pc_seq    = pc_value + STEP_W;
   assign top_entry = ras_mem[ptr_dec(wr_ptr)];
   assign br_target = pc_value + $unsigned(branch_off);

   // Next-PC selection in priority order: exc > stall > ret > jump > branch > seq.
   always_comb begin
      pc_nxt    = pc_seq;
      epc_nxt   = epc;
      fault_nxt = 1'b0;
      cause_nxt = fault_cause;
      push      = 1'b0;
      pop       = 1'b0;
      if (exc) begin
         pc_nxt  = EXC_PC;
         epc_nxt = pc_value;
      end else if (stall) begin
         pc_nxt = pc_value;
      end else if (ret) begin
         if (ras_count == '0) begin
            fault_nxt = 1'b1;
            cause_nxt = CAUSE_UFLOW;
            pc_nxt    = EXC_PC;
            epc_nxt   = pc_value;
         end else begin
            // The entry is consumed even if it turns out to be misaligned.
            pop = 1'b1;
            if (misaligned(top_entry)) begin
               fault_nxt = 1'b1;
               cause_nxt = CAUSE_ALIGN;
               pc_nxt    = EXC_PC;
               epc_nxt   = pc_value;
            end else begin
               pc_nxt = top_entry;
            end
         end
      end else if (jump) begin
         if (misaligned(target)) begin
            fault_nxt = 1'b1;
            cause_nxt = CAUSE_ALIGN;
            pc_nxt    = EXC_PC;
            epc_nxt   = pc_value;
         end else begin
            pc_nxt = target;
            push   = call;
         end
      end else if (branch) begin
         if (misaligned(br_target)) begin
            fault_nxt = 1'b1;
            cause_nxt = CAUSE_ALIGN;
            pc_nxt    = EXC_PC;
            epc_nxt   = pc_value;
         end else begin
            pc_nxt = br_target;
         end
      end
   end

   // Control state: PC, EPC, fault flags and stack bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_value    <= RST_PC;
         epc         <= '0;
         ras_count   <= '0;
         wr_ptr      <= '0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         pc_value    <= pc_nxt;
         epc         <= epc_nxt;
         fault       <= fault_nxt;
         fault_cause <= cause_nxt;
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
            if (ras_count != CNT_W'(RAS_DEPTH))
               ras_count <= ras_count + CNT_W'(1);
         end else if (pop) begin
            wr_ptr    <= ptr_dec(wr_ptr);
            ras_count <= ras_count - CNT_W'(1);
         end
      end
   end

   // Stack data needs no reset; a full stack simply overwrites its oldest slot.
   always_ff @(posedge clk) begin
      if (push)
         ras_mem[wr_ptr] <= pc_seq;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a queue-based reference model is compared
// against the DUT every cycle, with literal expectations on directed steps.
module tb_pc_unit;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               stall, branch, jump, call, ret, exc;
   logic signed [31:0] branch_off;
   logic        [31:0] target;
   logic        [31:0] pc_value, pc_seq, epc;
   logic        [2:0]  ras_count;
   logic               fault;
   logic        [1:0]  fault_cause;

   // Narrow instance for the wrap-around case.
   logic               s_zero = 1'b0;
   logic signed [7:0]  s_off  = 8'sd0;
   logic               s_jump = 1'b0;
   logic        [7:0]  s_target = 8'h00;
   logic        [7:0]  s_pc, s_seq, s_epc;
   logic        [2:0]  s_cnt;
   logic               s_fault;
   logic        [1:0]  s_cause;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(64'h0), .EXC_VECTOR(64'h80), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(rst_n), .stall(stall), .branch(branch), .branch_off(branch_off),
      .jump(jump), .call(call), .ret(ret), .target(target), .exc(exc),
      .pc_value(pc_value), .pc_seq(pc_seq), .epc(epc), .ras_count(ras_count),
      .fault(fault), .fault_cause(fault_cause));

   pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(64'h0), .EXC_VECTOR(64'h80), .RAS_DEPTH(4)) u_small (
      .clk(clk), .reset(rst_n), .stall(s_zero), .branch(s_zero), .branch_off(s_off),
      .jump(s_jump), .call(s_zero), .ret(s_zero), .target(s_target), .exc(s_zero),
      .pc_value(s_pc), .pc_seq(s_seq), .epc(s_epc), .ras_count(s_cnt),
      .fault(s_fault), .fault_cause(s_cause));

   always #5 clk = ~clk;

   // Reference model state.
   logic [31:0] m_pc, m_epc;
   logic [31:0] m_ras[$];
   logic        m_fault;
   logic [1:0]  m_cause;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_redirect_fault(input logic [1:0] cause);
      m_fault = 1'b1;
      m_cause = cause;
      m_epc   = m_pc;
      m_pc    = 32'h80;
   endtask

   task automatic m_step();
      logic [31:0] t;
      m_fault = 1'b0;
      if (exc) begin
         m_epc = m_pc;
         m_pc  = 32'h80;
      end else if (stall) begin
         // everything holds
      end else if (ret) begin
         if (m_ras.size() == 0) m_redirect_fault(2'b10);
         else begin
            t = m_ras.pop_back();
            if (t % 4 != 0) m_redirect_fault(2'b01);
            else m_pc = t;
         end
      end else if (jump) begin
         if (target % 4 != 0) m_redirect_fault(2'b01);
         else begin
            if (call) begin
               if (m_ras.size() == 4) void'(m_ras.pop_front());
               m_ras.push_back(m_pc + 32'd4);
            end
            m_pc = target;
         end
      end else if (branch) begin
         t = m_pc + branch_off;
         if (t % 4 != 0) m_redirect_fault(2'b01);
         else m_pc = t;
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   // Model advances on the same edges as the DUT, and resets asynchronously.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 32'h0; m_epc = 32'h0; m_fault = 1'b0; m_cause = 2'b00;
         m_ras.delete();
      end else begin
         m_step();
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_value", pc_value, m_pc);
         chk("pc_seq", pc_seq, m_pc + 32'd4);
         chk("epc", epc, m_epc);
         chk("ras_count", {29'd0, ras_count}, m_ras.size());
         chk("fault", {31'd0, fault}, {31'd0, m_fault});
         chk("fault_cause", {30'd0, fault_cause}, {30'd0, m_cause});
      end
   end

   task automatic clr();
      stall = 0; branch = 0; jump = 0; call = 0; ret = 0; exc = 0;
      branch_off = 0; target = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One clock edge with the given requests, then back to idle.
   task automatic op(input bit e, input bit s, input bit r, input bit j, input bit c,
                     input bit b, input logic [31:0] t, input logic [31:0] off);
      exc = e; stall = s; ret = r; jump = j; call = c; branch = b;
      target = t; branch_off = off;
      tick();
      clr();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [31:0] rv;
      clr();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      chk("reset pc", pc_value, 32'h0);
      chk("reset epc", epc, 32'h0);
      chk("reset ras_count", {29'd0, ras_count}, 32'd0);
      rst_n = 1'b1;
      #1 chk("post-release pc", pc_value, 32'h0);
      #1;

      tick(); chk("seq pc 4", pc_value, 32'h4);
      tick(); chk("seq pc 8", pc_value, 32'h8);
      tick(); chk("seq pc 12", pc_value, 32'hC);
      chk("pc_seq 16", pc_seq, 32'h10);

      op(0,0,0,1,0,0, 32'h100, 0);       chk("jump 0x100", pc_value, 32'h100);
      op(0,0,0,0,0,1, 0, -32'sd8);       chk("branch -8", pc_value, 32'hF8);
      op(0,0,0,1,0,1, 32'h2000, 32'h10); chk("jump beats branch", pc_value, 32'h2000);

      for (int a = 1; a <= 5; a++) begin
         op(0,0,0,1,0,0, a * 32'h10, 0);
         op(0,0,0,1,1,0, 32'h1000, 0);
      end
      chk("ras saturates", {29'd0, ras_count}, 32'd4);
      chk("call lands", pc_value, 32'h1000);
      op(0,0,1,0,0,0, 0, 0); chk("ret 1", pc_value, 32'h54);
      op(0,0,1,0,0,0, 0, 0); chk("ret 2", pc_value, 32'h44);
      op(0,0,1,0,0,0, 0, 0); chk("ret 3", pc_value, 32'h34);
      op(0,0,1,0,0,0, 0, 0); chk("ret 4", pc_value, 32'h24);
      op(0,0,0,1,0,0, 32'h1000, 0);
      op(0,0,1,0,0,0, 0, 0);
      chk("underflow fault", {31'd0, fault}, 32'd1);
      chk("underflow cause", {30'd0, fault_cause}, 32'd2);
      chk("underflow pc", pc_value, 32'h80);
      chk("underflow epc", epc, 32'h1000);
      tick();
      chk("fault one-shot", {31'd0, fault}, 32'd0);
      chk("cause holds", {30'd0, fault_cause}, 32'd2);

      op(0,0,0,1,0,0, 32'h300, 0);
      op(0,0,0,1,0,0, 32'h1002, 0);
      chk("misalign fault", {31'd0, fault}, 32'd1);
      chk("misalign cause", {30'd0, fault_cause}, 32'd1);
      chk("misalign pc", pc_value, 32'h80);
      chk("misalign epc", epc, 32'h300);
      op(0,0,0,1,0,0, 32'h40, 0);
      op(1,1,0,0,0,0, 0, 0);
      chk("exc over stall pc", pc_value, 32'h80);
      chk("exc over stall epc", epc, 32'h40);
      op(0,0,0,1,1,0, 32'h200, 0);
      op(0,1,0,1,1,0, 32'h500, 0);
      chk("stall holds pc", pc_value, 32'h200);
      chk("stall holds ras", {29'd0, ras_count}, 32'd1);
      op(0,0,0,1,1,0, 32'h1002, 0);
      chk("misaligned call no push", {29'd0, ras_count}, 32'd1);
      op(0,0,1,0,0,0, 0, 0);
      chk("ret after stall", pc_value, 32'h84);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 29); exc   = (r == 0);
         r = $urandom_range(0, 7);  stall = (r == 0);
         r = $urandom_range(0, 5);  ret   = (r == 0);
         r = $urandom_range(0, 3);  jump  = (r == 0);
         r = $urandom_range(0, 1);  call  = (r == 0);
         r = $urandom_range(0, 2);  branch = (r == 0);
         rv = $urandom_range(0, 32'hFFF);
         r = $urandom_range(0, 15);
         target = (r == 0) ? (rv | 32'h2) : (rv & ~32'h3);
         r = $urandom_range(0, 15);
         branch_off = $signed($urandom_range(0, 512)) - 32'sd256;
         branch_off = (r == 0) ? (branch_off | 32'sd1) : (branch_off & ~32'sd3);
         tick();
      end
      clr();

      s_target = 8'hFC; s_jump = 1'b1;
      tick();
      s_jump = 1'b0;
      chk("w8 pc 0xFC", {24'd0, s_pc}, 32'hFC);
      chk("w8 pc_seq wraps", {24'd0, s_seq}, 32'h0);
      tick();
      chk("w8 pc wraps", {24'd0, s_pc}, 32'h0);

      op(0,0,0,1,1,0, 32'h600, 0);
      chk("pre-reset ras nonzero", {31'd0, (ras_count != 0)}, 32'd1);
      jump = 1; call = 1; target = 32'h700;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async reset pc", pc_value, 32'h0);
      chk("async reset ras", {29'd0, ras_count}, 32'd0);
      chk("async reset epc", epc, 32'h0);
      clr();
      @(posedge clk); #2;
      rst_n = 1'b1;
      tick();
      chk("after reset seq", pc_value, 32'h4);

      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
